// File: rtl/layer5_serial_node.sv
// -----------------------------------------------------------------------------
// layer5_serial_node
//
// Time-multiplexed layer-5 neuron. One full vector of N_IN layer-4 ReLU
// outputs is captured per input handshake. A single shared 16x16 signed
// multiplier walks the vector one element per cycle, and the accumulator sums
// each product after an arithmetic right shift by FRAC. The accumulator starts
// at BIAS. The sum is then saturated to 0x7FFF and clamped at zero (ReLU) and
// offered on a valid/ready output.
//
// Parameters
//   N_IN   number of layer-4 activations (one per layer-4 node)
//   FRAC   fractional bits of activations, weights and bias (signed Q.FRAC)
//   W_VEC  packed weights, weight k at bits [16k+15:16k]
//   BIAS   16-bit signed bias
//
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous active-low reset
//   in_valid   act_in holds a complete layer-4 vector
//   in_ready   block can accept a vector (registered)
//   act_in     N_IN x 16 signed activations, element k at bits [16k+15:16k]
//   out_valid  out_data holds a result (registered)
//   out_ready  consumer accepts out_data
//   out_data   ReLU'd, saturated neuron output
// -----------------------------------------------------------------------------
module layer5_serial_node #(
   parameter int                N_IN  = 20,
   parameter int                FRAC  = 8,
   parameter logic [N_IN*16-1:0] W_VEC = '0,
   parameter logic [15:0]       BIAS  = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N_IN*16-1:0] act_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [15:0]        out_data
);

   localparam int IDX_W = $clog2(N_IN + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         state;
   logic [IDX_W-1:0]   idx;
   logic signed [31:0] acc;
   logic signed [15:0] act_bank [N_IN];

   logic signed [15:0] act_sel;
   logic signed [15:0] w_sel;
   logic signed [31:0] prod;
   logic signed [31:0] term;

   // Clamp negatives to zero, saturate above the largest positive 16-bit value.
   function automatic logic [15:0] sat_relu(input logic signed [31:0] a);
      if (a < 0)
         return 16'h0000;
      else if (a > 32'sd32767)
         return 16'h7FFF;
      else
         return a[15:0];
   endfunction

   // ---- operand select / shared multiplier ----
   always_comb begin
      act_sel = '0;
      w_sel   = '0;
      for (int k = 0; k < N_IN; k++) begin
         if (idx == IDX_W'(k)) begin
            act_sel = act_bank[k];
            w_sel   = signed'(W_VEC[16*k +: 16]);
         end
      end
      prod = 32'(act_sel) * 32'(w_sel);
      // Arithmetic shift: each term truncates toward minus infinity.
      term = prod >>> FRAC;
   end

   // ---- control, accumulator and output registers ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         idx       <= '0;
         acc       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         for (int k = 0; k < N_IN; k++)
            act_bank[k] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  for (int k = 0; k < N_IN; k++)
                     act_bank[k] <= signed'(act_in[16*k +: 16]);
                  acc      <= {{16{BIAS[15]}}, BIAS};
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= S_MAC;
               end else begin
                  // Raises in_ready on the first edge after reset release.
                  in_ready <= 1'b1;
               end
            end
            S_MAC: begin
               // idx == N_IN is the extra cycle that registers the finished
               // sum, so the result appears one edge after the last product.
               if (idx == IDX_W'(N_IN)) begin
                  out_data  <= sat_relu(acc);
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  acc <= acc + term;
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
